// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
//   fs_state_e       - fetch FSM states (issue address / SRAM response / hold for decode)
//   RESET_PC_DEFAULT - default first fetch address after reset
//   PC_INCR          - sequential PC increment
`timescale 1ns/1ps

package if_pkg;

    typedef enum logic [1:0] {
        StIssue = 2'd0,
        StResp  = 2'd1,
        StHold  = 2'd2
    } fs_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

endpackage

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch for the multi-cycle LoongArch core.
// Owns the PC, drives a synchronous (1-cycle latency) instruction SRAM, captures the
// returned word and offers one instruction at a time to decode via valid/ready.
// Branch/jump redirects (br_taken pulse) win over everything and flush in-flight data.
//
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   inst_sram_*          - SRAM request (we/wdata tied 0, addr registered = req_pc)
//   inst_sram_rdata      - SRAM read data, valid the cycle after the address
//   br_taken, br_target  - redirect pulse and target
//   fs_valid, fs_ready   - handshake to decode
//   fs_pc, fs_inst       - delivered instruction and its PC
//   fs_excp_adef         - misaligned fetch address flag
//
// Build option: define IF_ADEF_CHECK_EN to flag misaligned fetch addresses instead of
// issuing them to the SRAM. Without it fs_excp_adef is tied to 0.
`timescale 1ns/1ps

module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,

    input  logic        br_taken,
    input  logic [31:0] br_target,

    output logic        fs_valid,
    input  logic        fs_ready,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_excp_adef
);

    fs_state_e   state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic [31:0] fs_inst_q, fs_inst_d;

    // fs_valid is only ever set in HOLD, so a handshake implies HOLD.
    logic handshake;
    assign handshake = fs_valid_q & fs_ready;

    // Misaligned address seen while issuing; only meaningful with the check enabled.
    logic adef_hit;
`ifdef IF_ADEF_CHECK_EN
    assign adef_hit = (state_q == StIssue) && (req_pc_q[1:0] != 2'b00);
`else
    assign adef_hit = 1'b0;
`endif

    // ---------------- State register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIssue;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (br_taken) begin
            state_d = StIssue;
        end else begin
            unique case (state_q)
                StIssue: state_d = adef_hit ? StHold : StResp;
                StResp:  state_d = StHold;
                StHold:  state_d = handshake ? StIssue : StHold;
                default: state_d = StIssue;
            endcase
        end
    end

    // ---------------- Datapath next values ----------------
    always_comb begin
        req_pc_d   = req_pc_q;
        fs_valid_d = fs_valid_q;
        fs_pc_d    = fs_pc_q;
        fs_inst_d  = fs_inst_q;

        // Next-PC mux: redirect target, sequential successor, or hold.
        if (br_taken) begin
            req_pc_d = br_target;
        end else if (handshake) begin
            req_pc_d = fs_pc_q + PC_INCR;
        end

        if (br_taken) begin
            // In-flight response (if any) is dropped; the offered instruction is withdrawn.
            fs_valid_d = 1'b0;
        end else if (state_q == StResp) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = req_pc_q;
            fs_inst_d  = inst_sram_rdata;
        end else if (adef_hit) begin
            fs_valid_d = 1'b1;
            fs_pc_d    = req_pc_q;
            fs_inst_d  = 32'h0;
        end else if (handshake) begin
            fs_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_pc_q   <= RESET_PC;
            fs_valid_q <= 1'b0;
            fs_pc_q    <= 32'h0;
            fs_inst_q  <= 32'h0;
        end else begin
            req_pc_q   <= req_pc_d;
            fs_valid_q <= fs_valid_d;
            fs_pc_q    <= fs_pc_d;
            fs_inst_q  <= fs_inst_d;
        end
    end

`ifdef IF_ADEF_CHECK_EN
    logic fs_adef_q, fs_adef_d;

    always_comb begin
        fs_adef_d = fs_adef_q;
        if (br_taken || handshake) begin
            fs_adef_d = 1'b0;
        end else if (adef_hit) begin
            fs_adef_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_adef_q <= 1'b0;
        end else begin
            fs_adef_q <= fs_adef_d;
        end
    end

    assign fs_excp_adef = fs_adef_q;
`else
    assign fs_excp_adef = 1'b0;
`endif

    // ---------------- Outputs (all registered) ----------------
    assign inst_sram_we    = 1'b0;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = req_pc_q;
    assign fs_valid        = fs_valid_q;
    assign fs_pc           = fs_pc_q;
    assign fs_inst         = fs_inst_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. The SRAM model returns {addr[31:2],2'b00}^A5A5A5A5
// one cycle after the address. Inputs change 1 time unit after a rising edge; outputs are
// checked at that same point, i.e. they show the state of the cycle just entered.
`timescale 1ns/1ps

module tb_if_fetch_stage;

    localparam logic [31:0] RstPc = 32'h1c00_0000;
    localparam logic [31:0] Xmask = 32'hA5A5_A5A5;

    logic        clk;
    logic        resetn;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_valid;
    logic        fs_ready;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_excp_adef;

    int total;
    int bad;

    if_fetch_stage #(.RESET_PC(RstPc)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .fs_valid        (fs_valid),
        .fs_ready        (fs_ready),
        .fs_pc           (fs_pc),
        .fs_inst         (fs_inst),
        .fs_excp_adef    (fs_excp_adef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-aligned synchronous SRAM model.
    always @(posedge clk) begin
        inst_sram_rdata <= {inst_sram_addr[31:2], 2'b00} ^ Xmask;
    end

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ Xmask;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_br(input logic [31:0] tgt);
        br_taken  = 1'b1;
        br_target = tgt;
        step();
        br_taken  = 1'b0;
        br_target = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, {31'h0, fs_valid}, 32'h0);
        check_eq({tag, "_pc"}, fs_pc, 32'h0);
        check_eq({tag, "_inst"}, fs_inst, 32'h0);
        check_eq({tag, "_adef"}, {31'h0, fs_excp_adef}, 32'h0);
        check_eq({tag, "_addr"}, inst_sram_addr, RstPc);
        check_eq({tag, "_we"}, {31'h0, inst_sram_we}, 32'h0);
        check_eq({tag, "_wdata"}, inst_sram_wdata, 32'h0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        resetn    = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        fs_ready  = 1'b1;

        step();
        step();
        check_reset_outputs("rst");
        resetn = 1'b1;   // current cycle is now cycle 0 (ISSUE)

        // 1) Sequential fetch with decode always ready: one instruction every 3 cycles.
        for (int c = 0; c < 9; c++) begin
            check_eq("seq_valid", {31'h0, fs_valid}, {31'h0, (c % 3) == 2});
            if ((c % 3) == 2) begin
                check_eq("seq_pc", fs_pc, RstPc + 32'(4 * (c / 3)));
                check_eq("seq_inst", fs_inst, exp_word(RstPc + 32'(4 * (c / 3))));
            end
            if (c == 8) fs_ready = 1'b0;
            step();
        end

        // 2) Decode stalls 10 cycles on 1c000008: everything frozen.
        for (int c = 0; c < 10; c++) begin
            check_eq("hold_valid", {31'h0, fs_valid}, 32'h1);
            check_eq("hold_pc", fs_pc, 32'h1c00_0008);
            check_eq("hold_inst", fs_inst, exp_word(32'h1c00_0008));
            check_eq("hold_addr", inst_sram_addr, 32'h1c00_0008);
            step();
        end
        fs_ready = 1'b1;
        step();
        fs_ready = 1'b0;
        check_eq("rel_addr", inst_sram_addr, 32'h1c00_000c);
        check_eq("rel_valid1", {31'h0, fs_valid}, 32'h0);
        step();
        check_eq("rel_valid2", {31'h0, fs_valid}, 32'h0);
        step();
        check_eq("rel_valid3", {31'h0, fs_valid}, 32'h1);
        check_eq("rel_pc", fs_pc, 32'h1c00_000c);

        // 3) Redirect during RESP: the 1c000010 response is discarded.
        fs_ready = 1'b1;
        step();
        fs_ready = 1'b0;
        check_eq("resp_addr", inst_sram_addr, 32'h1c00_0010);
        step();          // RESP cycle for 1c000010
        pulse_br(32'h1c00_0100);
        check_eq("brr_addr", inst_sram_addr, 32'h1c00_0100);
        check_eq("brr_valid1", {31'h0, fs_valid}, 32'h0);
        step();
        check_eq("brr_valid2", {31'h0, fs_valid}, 32'h0);
        step();
        check_eq("brr_valid3", {31'h0, fs_valid}, 32'h1);
        check_eq("brr_pc", fs_pc, 32'h1c00_0100);
        check_eq("brr_inst", fs_inst, exp_word(32'h1c00_0100));

        // 4) Redirect coincident with handshake of 1c000010.
        pulse_br(32'h1c00_0010);
        step();
        step();
        check_eq("co_pre_valid", {31'h0, fs_valid}, 32'h1);
        check_eq("co_pre_pc", fs_pc, 32'h1c00_0010);
        fs_ready = 1'b1;
        pulse_br(32'h1c00_0040);
        fs_ready = 1'b0;
        check_eq("co_addr", inst_sram_addr, 32'h1c00_0040);
        check_eq("co_valid1", {31'h0, fs_valid}, 32'h0);
        step();
        check_eq("co_valid2", {31'h0, fs_valid}, 32'h0);
        step();
        check_eq("co_valid3", {31'h0, fs_valid}, 32'h1);
        check_eq("co_pc", fs_pc, 32'h1c00_0040);

        // 5) PC wraps from FFFFFFFC to 00000000.
        pulse_br(32'hFFFF_FFFC);
        step();
        step();
        check_eq("wrap_pc", fs_pc, 32'hFFFF_FFFC);
        check_eq("wrap_inst", fs_inst, exp_word(32'hFFFF_FFFC));
        fs_ready = 1'b1;
        step();
        fs_ready = 1'b0;
        check_eq("wrap_addr", inst_sram_addr, 32'h0000_0000);

        // 6) Misaligned redirect target.
        pulse_br(32'h1c00_0102);
        check_eq("mis_addr", inst_sram_addr, 32'h1c00_0102);
        step();
`ifdef IF_ADEF_CHECK_EN
        check_eq("mis_valid", {31'h0, fs_valid}, 32'h1);
        check_eq("mis_adef", {31'h0, fs_excp_adef}, 32'h1);
        check_eq("mis_inst", fs_inst, 32'h0);
        check_eq("mis_pc", fs_pc, 32'h1c00_0102);
`else
        check_eq("mis_valid0", {31'h0, fs_valid}, 32'h0);
        step();
        check_eq("mis_valid", {31'h0, fs_valid}, 32'h1);
        check_eq("mis_adef", {31'h0, fs_excp_adef}, 32'h0);
        check_eq("mis_inst", fs_inst, exp_word(32'h1c00_0102));
        check_eq("mis_pc", fs_pc, 32'h1c00_0102);
`endif
        fs_ready = 1'b1;
        step();
        fs_ready = 1'b0;
        check_eq("mis_clr_adef", {31'h0, fs_excp_adef}, 32'h0);
        check_eq("mis_clr_valid", {31'h0, fs_valid}, 32'h0);
        check_eq("mis_next_addr", inst_sram_addr, 32'h1c00_0106);

        // 7) Asynchronous reset while holding an instruction.
        step();
        step();
        check_eq("pre_rst_valid", {31'h0, fs_valid}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        step();
        resetn = 1'b1;
        check_eq("restart_addr", inst_sram_addr, RstPc);
        step();
        check_eq("restart_valid1", {31'h0, fs_valid}, 32'h0);
        step();
        check_eq("restart_valid2", {31'h0, fs_valid}, 32'h1);
        check_eq("restart_pc", fs_pc, RstPc);
        check_eq("restart_inst", fs_inst, exp_word(RstPc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage for the multi-cycle LoongArch core. It owns the PC and drives the synchronous instruction SRAM, which has a one-cycle read latency. It captures each returned instruction and hands exactly one instruction at a time to the decode stage over a valid/ready handshake. It applies branch/jump redirects from decode/execute.

## Interface
Parameters:
- RESET_PC, 32'h1c00_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_sram_we  out  1  constant 0.
- inst_sram_addr  out  32  fetch address; registered, equals req_pc.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_rdata  in  32  instruction; valid the cycle after the address is presented.
- br_taken  in  1  single-cycle redirect pulse.
- br_target  in  32  redirect address; sampled when br_taken=1.
- fs_valid  out  1  fs_pc/fs_inst hold a deliverable instruction.
- fs_ready  in  1  decode accepts; transfer occurs when fs_valid & fs_ready.
- fs_pc  out  32  PC of the delivered instruction.
- fs_inst  out  32  delivered instruction word.
- fs_excp_adef  out  1  fetch-address-misaligned flag for the delivered instruction (see Configuration).

## Operation
- State machine states: ISSUE, RESP, HOLD.
- ISSUE: req_pc is on inst_sram_addr. Next state is RESP.
- RESP: inst_sram_rdata is valid.
  - Capture fs_inst<=rdata, fs_pc<=req_pc, fs_valid<=1.
  - Next state is HOLD.
- HOLD: fs_valid=1 and all outputs are stable until the handshake occurs.
  - On fs_valid & fs_ready: req_pc<=fs_pc+4, fs_valid<=0, next state is ISSUE.
- Redirect: br_taken=1 in any state.
  - req_pc<=br_target, fs_valid<=0, next state is ISSUE.
  - Any in-flight RESP data is discarded.
  - Redirect has priority over a simultaneous handshake; the handed-over instruction still counts as accepted.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- fs_ready while fs_valid=0 is ignored.
- Reset values (asynchronous on resetn=0):
  - state=ISSUE, req_pc=RESET_PC, inst_sram_addr=RESET_PC.
  - fs_valid=0, fs_pc=0, fs_inst=0, fs_excp_adef=0.
- Reset asserted mid-operation: all of the above values are applied immediately; any captured or in-flight instruction is lost.

## Timing
- After resetn rises: ISSUE in cycle 0, RESP in cycle 1, fs_valid=1 from cycle 2.
- Handshake at cycle t: fs_valid=0 in t+1 and t+2; the next instruction has fs_valid=1 from t+3.
- Redirect at cycle t: inst_sram_addr=br_target in t+1; fs_valid=1 with fs_pc=br_target from t+3.
- Throughput: at most one instruction per 3 cycles, which matches the multi-cycle core's per-instruction cost.
- No combinational path from fs_ready or br_taken to any output.

## Configuration
- IF_ADEF_CHECK_EN defined:
  - In ISSUE with req_pc[1:0]!=2'b00, the SRAM response is not used.
  - The next state is HOLD directly, with fs_valid=1, fs_pc=req_pc, fs_inst=32'h0, fs_excp_adef=1.
  - fs_excp_adef clears on the handshake or on redirect.
- IF_ADEF_CHECK_EN undefined:
  - fs_excp_adef is tied to 0.
  - Misaligned addresses are issued unchanged, and the SRAM returns the word at addr[31:2].
- The port list is identical in both builds.

## Structure
- Shared package if_pkg contains:
  - the state enum (ISSUE/RESP/HOLD);
  - the default RESET_PC constant;
  - the PC increment constant 32'd4.
- Single flat module; no sub-module is warranted.
- Next-PC selection is an always_comb mux: br_target, fs_pc+4, or hold.

## Test plan
- Reset release with fs_ready=1 and SRAM returning addr^32'hA5A5_A5A5 → fs_pc sequence 1c000000, 1c000004, 1c000008; fs_valid pulses every 3rd cycle with the matching fs_inst.
- fs_ready held 0 for 10 cycles in HOLD → fs_pc, fs_inst and fs_valid stay constant and inst_sram_addr stays unchanged; raising fs_ready → next fetch at fs_pc+4.
- br_taken pulse with br_target=1c000100 during RESP → the captured word is discarded; next delivered fs_pc=1c000100 three cycles after the pulse.
- br_taken coincident with a handshake at fs_pc=1c000010, br_target=1c000040 → next fs_pc=1c000040, never 1c000014.
- req_pc=FFFFFFFC delivered and accepted → the next inst_sram_addr is 00000000.
- With IF_ADEF_CHECK_EN: br_target=1c000102 → fs_valid=1, fs_excp_adef=1, fs_inst=0, fs_pc=1c000102 two cycles after the pulse. Without the macro, the same stimulus gives fs_excp_adef=0 and the SRAM word.
- resetn pulsed low during HOLD → all outputs return to their reset values immediately; fetch restarts at RESET_PC.
